lfo_tremolo: RTL and testbench

LFO_TREMOLO -- requirements
Module: lfo_tremolo

---
 rtl/lfo_tremolo.sv | 128 ++++++++++++
 tb/tb_lfo_tremolo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfo_tremolo.sv
// lfo_tremolo: scales a signed audio sample by an unsigned LFO gain (512 = unity)
// using a bit-serial shift-add multiplier. The result is floored by >>> 9.
// Build option: define TREMOLO_SATURATE_EN to clamp the result to DATA_W bits;
// without it the low DATA_W bits are kept and the result wraps on overflow.
module lfo_tremolo #(
   parameter int DATA_W = 24,
   parameter int LFO_W  = 10
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [LFO_W-1:0]  lfo_value,
   input  logic              lfo_strobe,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_sample,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned PROD_W = DATA_W + LFO_W;
   localparam int unsigned CNT_W  = $clog2(LFO_W + 1);
   localparam int unsigned SHIFT  = 9;
   localparam logic [LFO_W-1:0] UNITY    = LFO_W'(512);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LFO_W);

   typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

   state_t                    state_q, state_n;
   logic                      accept_c;
   logic                      mul_done_c;
   logic [LFO_W-1:0]          gain_q;
   logic [PROD_W-1:0]         mcand_q;
   logic [LFO_W-1:0]          mplier_q;
   logic signed [PROD_W-1:0]  acc_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [DATA_W-1:0]         reduced_c;

   // Next-state decode; MUL holds LFO_W add cycles plus one result cycle
   always_comb begin
      state_n    = state_q;
      accept_c   = 1'b0;
      mul_done_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               state_n  = MUL;
            end
         end
         MUL: begin
            if (cnt_q == LAST_CNT) begin
               mul_done_c = 1'b1;
               state_n    = OUT;
            end
         end
         OUT: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; in_ready is registered from the next state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         in_ready <= 1'b1;
      end else begin
         state_q  <= state_n;
         in_ready <= (state_n == IDLE);
      end
   end

   // Gain register, serial multiplier and output register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gain_q     <= UNITY;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else begin
         if (lfo_strobe) gain_q <= lfo_value;
         if (accept_c) begin
            // gain_q still holds the pre-edge value here, so a coincident strobe
            // only affects later samples
            mcand_q  <= {{LFO_W{in_sample[DATA_W-1]}}, in_sample};
            mplier_q <= gain_q;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else if (state_q == MUL && !mul_done_c) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
         end
         if (mul_done_c) begin
            out_sample <= reduced_c;
            out_valid  <= 1'b1;
         end else if (state_q == OUT && out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

`ifdef TREMOLO_SATURATE_EN
   localparam logic signed [PROD_W-1:0] SAT_MAX = {{(LFO_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN = {{(LFO_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [PROD_W-1:0] shifted_c;

   // Floor-shift the product and clamp it into the signed DATA_W range
   always_comb begin
      shifted_c = acc_q >>> SHIFT;
      if (shifted_c > SAT_MAX)      reduced_c = SAT_MAX[DATA_W-1:0];
      else if (shifted_c < SAT_MIN) reduced_c = SAT_MIN[DATA_W-1:0];
      else                          reduced_c = shifted_c[DATA_W-1:0];
   end
`else
   // Floor-shift the product and keep the low DATA_W bits (wraps on overflow)
   always_comb begin
      reduced_c = acc_q[SHIFT +: DATA_W];
   end
`endif

endmodule

// File: tb/tb_lfo_tremolo.sv
// Bench for lfo_tremolo: stimulus pushes expected results into a scoreboard,
// a negedge monitor pops on each out_valid rise and checks data, latency,
// hold stability and the return to IDLE.
module tb_lfo_tremolo;

   localparam int DATA_W  = 24;
   localparam int LFO_W   = 10;
   localparam int LATENCY = LFO_W + 1;

   logic              CLK;
   logic              RST_N;
   logic [LFO_W-1:0]  lfo_value;
   logic              lfo_strobe;
   logic [DATA_W-1:0] in_sample;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_sample;
   logic              out_valid;
   logic              out_ready;

   lfo_tremolo #(.DATA_W(DATA_W), .LFO_W(LFO_W)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .lfo_value  (lfo_value),
      .lfo_strobe (lfo_strobe),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      longint exp_v;
      longint acc_edge;
   } sb_t;

   sb_t    sb[$];
   int     checks   = 0;
   int     failures = 0;
   longint edge_cnt = 0;
   longint model_gain = 512;
   bit     hs_q   = 1'b0;
   bit     hold_q = 1'b0;
   bit     prev_valid = 1'b0;
   longint held_sample = 0;
   bit     rdy_auto = 1'b1;

   task automatic check(input string name, input longint act, input longint exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Reference: full-precision product, floored divide by 512, then reduce
   function automatic longint model(input longint s, input longint g);
      longint sh;
      longint w;
      sh = (s * g) >>> 9;
`ifdef TREMOLO_SATURATE_EN
      if (sh > 64'sd8388607) w = 64'sd8388607;
      else if (sh < -64'sd8388608) w = -64'sd8388608;
      else w = sh;
`else
      w = sh & 64'sh0000_0000_00FF_FFFF;
      if (w >= 64'sd8388608) w = w - 64'sd16777216;
`endif
      return w;
   endfunction

   // Edge counter and handshake flags sampled on the active edge
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hs_q   = 1'b0;
         hold_q = 1'b0;
      end else begin
         edge_cnt++;
         hs_q   = out_valid && out_ready;
         hold_q = out_valid && !out_ready;
      end
   end

   // Random backpressure driver
   always @(negedge CLK) begin
      if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops the scoreboard on every out_valid rise
   always @(negedge CLK) begin
      if (RST_N) begin
         if (hold_q) begin
            check("hold_valid", longint'(out_valid), 1);
            check("hold_data", longint'($signed(out_sample)), held_sample);
            check("hold_in_ready", longint'(in_ready), 0);
         end
         if (hs_q) begin
            check("release_valid", longint'(out_valid), 0);
            check("release_in_ready", longint'(in_ready), 1);
         end
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               sb_t it;
               it = sb.pop_front();
               check("out_sample", longint'($signed(out_sample)), it.exp_v);
               check("latency", edge_cnt - it.acc_edge, LATENCY);
            end
         end
         if (out_valid) held_sample = longint'($signed(out_sample));
         prev_valid = out_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   // Offer one sample; optional coincident strobe; optional fixed expectation
   task automatic xfer(input longint s, input bit stb, input int lv,
                       input bit use_exp, input longint exp_v);
      int   n;
      sb_t  it;
      @(negedge CLK);
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      in_sample  = DATA_W'(s);
      in_valid   = 1'b1;
      lfo_strobe = stb;
      lfo_value  = LFO_W'(lv);
      it.exp_v    = use_exp ? exp_v
                            : model(longint'($signed(DATA_W'(s))), model_gain);
      it.acc_edge = edge_cnt + 1;
      sb.push_back(it);
      @(posedge CLK);
      if (stb) model_gain = longint'(lv);
      @(negedge CLK);
      in_valid   = 1'b0;
      lfo_strobe = 1'b0;
   endtask

   task automatic strobe_only(input int lv);
      @(negedge CLK);
      lfo_strobe = 1'b1;
      lfo_value  = LFO_W'(lv);
      @(posedge CLK);
      model_gain = longint'(lv);
      @(negedge CLK);
      lfo_strobe = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge CLK);
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check("drain_empty", longint'(sb.size()), 0);
   endtask

   initial begin
      longint sat_exp;
      RST_N      = 1'b0;
      lfo_value  = '0;
      lfo_strobe = 1'b0;
      in_sample  = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      #12;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_out_sample", longint'($signed(out_sample)), 0);
      check("reset_in_ready", longint'(in_ready), 1);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("post_reset_in_ready", longint'(in_ready), 1);

      // Unity gain passes the sample through with fixed latency
      strobe_only(512);
      xfer(1000, 1'b0, 0, 1'b1, 1000);
      // Half gain, floor on negatives
      strobe_only(256);
      xfer(-2000, 1'b0, 0, 1'b1, -1000);
      xfer(-1, 1'b0, 0, 1'b1, -1);
      // Overflow: clamp or wrap depending on build
`ifdef TREMOLO_SATURATE_EN
      sat_exp = 8388607;
`else
      sat_exp = -7569410;
`endif
      strobe_only(562);
      xfer(8388607, 1'b0, 0, 1'b1, sat_exp);
      // Zero gain gives zero
      strobe_only(0);
      xfer(longint'($signed(DATA_W'($urandom))), 1'b0, 0, 1'b1, 0);
      drain();

      // Backpressure: hold out_ready low 5 cycles in OUT
      rdy_auto  = 1'b0;
      out_ready = 1'b0;
      strobe_only(300);
      xfer(-123456, 1'b0, 0, 1'b0, 0);
      wait_valid();
      repeat (5) begin
         @(negedge CLK);
         check("stall_in_ready", longint'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      @(negedge CLK);
      check("after_release_in_ready", longint'(in_ready), 1);
      rdy_auto = 1'b1;

      // Strobe coincident with accept applies to the next sample only
      strobe_only(512);
      xfer(1000, 1'b1, 256, 1'b1, 1000);
      xfer(1000, 1'b0, 0, 1'b1, 500);
      drain();

      // Reset mid-MUL discards the in-flight sample and restores unity gain
      strobe_only(700);
      xfer(5000, 1'b0, 0, 1'b0, 0);
      repeat (3) @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      sb.delete();
      model_gain = 512;
      check("midreset_out_valid", longint'(out_valid), 0);
      check("midreset_out_sample", longint'($signed(out_sample)), 0);
      check("midreset_in_ready", longint'(in_ready), 1);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("midreset_release_in_ready", longint'(in_ready), 1);
      repeat (15) begin
         @(negedge CLK);
         check("midreset_no_output", longint'(out_valid), 0);
      end
      xfer(1000, 1'b0, 0, 1'b1, 1000);
      drain();

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) strobe_only(int'($urandom_range(0, 1023)));
         xfer(longint'($signed(DATA_W'($urandom))), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 1023)), 1'b0, 0);
         if ($urandom_range(0, 2) == 0) strobe_only(int'($urandom_range(0, 1023)));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
